iot_interrupt_ctrl: RTL and testbench
=====================================

Name: iot_interrupt_ctrl

Overview:
- Processor-side interrupt controller for IOT group 600x (ION, IOF, SKON, SRQ, GTF, RTF, CAF).
- Owns the interrupt-enable state machine, including the one-instruction ION delay.
- Arbitrates NDEV level-sensitive device requests with fixed priority.
- Issues a registered interrupt-take pulse to the major-state sequencer at instruction boundaries.

Parameters:
- NDEV, 8, number of device request lines.
- SRCW, 3, width of IRQ_SRC; must be at least ceil(log2(NDEV)).

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IOT600X  in  1  decoded group-600x strobe; valid when EXEC_STB=1.
- IR_LO  in  3  IR[2:0], the sub-operation select.
- EXEC_STB  in  1  one-cycle pulse: perform the IOT action.
- INSTR_DONE  in  1  one-cycle pulse on the last cycle of every instruction.
- DEV_REQ  in  NDEV  device interrupt requests, level; bit 0 has highest priority.
- LINK_IN  in  1  current link value, used by GTF.
- DATA_IN  in  12  AC value, used by RTF.
- SKIP  out  1  combinational skip request, valid only while EXEC_STB=1.
- IE  out  1  interrupts enabled (state ION_DLY or ON).
- IRQ_TAKE  out  1  registered one-cycle pulse: force the interrupt fetch.
- IRQ_SRC  out  SRCW  index of the granted device, latched with IRQ_TAKE.
- CAF_CLR  out  1  registered one-cycle pulse: clear all device flags.
- DATA_OUT  out  12  GTF data word; 0 when GTF is not executing.
- LINK_LOAD  out  1  one-cycle pulse during RTF.
- LINK_VAL  out  1  link value to load during RTF.

Behaviour:
- Reset: state OFF; IE, IRQ_TAKE, CAF_CLR, LINK_LOAD, LINK_VAL = 0; IRQ_SRC = 0; DATA_OUT = 0.
- An op executes only when EXEC_STB & IOT600X.
- States:
  - OFF
  - ION_WAIT: ION executed, its instruction not yet finished.
  - ION_DLY: one more instruction must complete before interrupts are taken.
  - ON
- Op 6001 ION:
  - From OFF → ION_WAIT. If INSTR_DONE is asserted in the same cycle → ION_DLY directly.
  - From ION_WAIT, ION_DLY or ON: no change.
- Op 6002 IOF: any state → OFF at the next edge; this overrides a coincident INSTR_DONE.
- Op 6000 SKON: SKIP=1 if the state is not OFF; state → OFF.
- Op 6003 SRQ: SKIP=1 if |DEV_REQ.
- Op 6007 CAF: state → OFF; CAF_CLR=1 for the next cycle.
- Ops 6006, 6004, 6005: no operation when the feature is off; SKIP=0.
- INSTR_DONE, when no state-changing op executes in the same cycle:
  - ION_WAIT → ION_DLY.
  - ION_DLY or ON with |DEV_REQ=1 → IRQ_TAKE=1 next cycle; IRQ_SRC = lowest set index; state → OFF.
  - ION_DLY or ON with |DEV_REQ=0 → ON.
- IRQ_TAKE, CAF_CLR and LINK_LOAD are exactly one cycle wide; a pending pulse is not extended.
- DEV_REQ is sampled only on the INSTR_DONE cycle; requests that drop between boundaries are ignored.
- RESET asserted mid-pulse clears the pulse immediately (asynchronous).
- SKIP is purely combinational from the current state, IR_LO and DEV_REQ, so it must be captured in the same cycle.

Optional Feature:
- Macro: IOT_INT_GTF_RTF_EN.
- With the macro:
  - 6004 GTF: DATA_OUT[11]=LINK_IN, DATA_OUT[9]=|DEV_REQ, DATA_OUT[7]=(state != OFF), all other bits 0. Combinational, during EXEC_STB only.
  - 6005 RTF: LINK_LOAD=1 with LINK_VAL=DATA_IN[11] for one cycle. If DATA_IN[7]=1, behave as ION, including the delay; otherwise state → OFF.
- Without the macro: GTF and RTF are no-ops; DATA_OUT, LINK_LOAD and LINK_VAL are tied to 0.

Test Plan:
- Reset → IE=0, IRQ_TAKE=0, IRQ_SRC=0. Then ION with DEV_REQ=8'h04 held → no IRQ_TAKE on the ION's INSTR_DONE; IRQ_TAKE=1 with IRQ_SRC=2 one cycle after the next INSTR_DONE; IE=0 afterwards.
- ION, then IOF before the following INSTR_DONE, with DEV_REQ=8'hFF → IRQ_TAKE is never asserted; state OFF.
- State ON, DEV_REQ=8'h90 at INSTR_DONE → IRQ_SRC=4, a single IRQ_TAKE pulse; a second INSTR_DONE gives no pulse.
- SKON with state ON → SKIP=1, then IE=0; SKON with state OFF → SKIP=0. SRQ with DEV_REQ=0 → SKIP=0; with DEV_REQ=8'h01 → SKIP=1.
- CAF in state ON → CAF_CLR high for exactly one cycle; IE=0. RESET asserted during IRQ_TAKE → the pulse drops immediately.
- IOT_INT_GTF_RTF_EN defined, LINK_IN=1, state ON, DEV_REQ≠0 → GTF gives DATA_OUT=12'o5200. RTF with DATA_IN=12'o4200 → LINK_LOAD pulse with LINK_VAL=1; state ION_WAIT.

Source files
------------

// File: rtl/iot_interrupt_ctrl.sv
// Interrupt controller for IOT group 600x: enable FSM with ION delay, fixed-priority request arbitration.
// Optional GTF/RTF support is compiled in with `define IOT_INT_GTF_RTF_EN.
module iot_interrupt_ctrl #(
  parameter int NDEV = 8,
  parameter int SRCW = 3
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IOT600X,
  input  logic [2:0]      IR_LO,
  input  logic            EXEC_STB,
  input  logic            INSTR_DONE,
  input  logic [NDEV-1:0] DEV_REQ,
  input  logic            LINK_IN,
  input  logic [11:0]     DATA_IN,
  output logic            SKIP,
  output logic            IE,
  output logic            IRQ_TAKE,
  output logic [SRCW-1:0] IRQ_SRC,
  output logic            CAF_CLR,
  output logic [11:0]     DATA_OUT,
  output logic            LINK_LOAD,
  output logic            LINK_VAL,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ION_WAIT = 2'd1,
    ST_ION_DLY  = 2'd2,
    ST_ON       = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            exec;
  logic            op_skon, op_ion, op_iof, op_srq, op_caf, op_gtf, op_rtf;
  logic            any_req;
  logic            force_off;
  logic            arm_ion;
  logic            take_nxt;
  logic [SRCW-1:0] grant_idx;
  logic            irq_take;
  logic [SRCW-1:0] irq_src;
  logic            caf_clr;
  logic            link_load;
  logic            link_val;

  // EXEC_STB and INSTR_DONE are single-cycle strobes with no back-pressure:
  // an op acts in exactly the cycle EXEC_STB & IOT600X is high.
  assign exec    = EXEC_STB & IOT600X;
  assign op_skon = exec & (IR_LO == 3'd0);
  assign op_ion  = exec & (IR_LO == 3'd1);
  assign op_iof  = exec & (IR_LO == 3'd2);
  assign op_srq  = exec & (IR_LO == 3'd3);
  assign op_caf  = exec & (IR_LO == 3'd7);
  assign any_req = |DEV_REQ;

`ifdef IOT_INT_GTF_RTF_EN
  logic unused_data;
  assign op_gtf      = exec & (IR_LO == 3'd4);
  assign op_rtf      = exec & (IR_LO == 3'd5);
  assign unused_data = ^{DATA_IN[10:8], DATA_IN[6:0]};
  assign DATA_OUT    = op_gtf ? {LINK_IN, 1'b0, any_req, 1'b0, (state != ST_OFF), 7'b0} : 12'd0;
`else
  logic unused_data;
  assign op_gtf      = 1'b0;
  assign op_rtf      = 1'b0;
  assign unused_data = ^{DATA_IN, LINK_IN, op_gtf};
  assign DATA_OUT    = 12'd0;
`endif

  // RTF with AC[7] set enables exactly like ION; with AC[7] clear it disables.
  assign force_off = op_skon | op_iof | op_caf | (op_rtf & ~DATA_IN[7]);
  assign arm_ion   = op_ion | (op_rtf & DATA_IN[7]);

  // Lowest set request index wins.
  always_comb begin
    grant_idx = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (DEV_REQ[i]) grant_idx = SRCW'(i);
    end
  end

  // ION from OFF lands in ION_WAIT first, so a coincident INSTR_DONE only reaches ION_DLY.
  always_comb begin
    state_nxt = state;
    take_nxt  = 1'b0;
    if (force_off) begin
      state_nxt = ST_OFF;
    end else begin
      if (arm_ion && (state == ST_OFF)) state_nxt = ST_ION_WAIT;
      if (INSTR_DONE) begin
        case (state_nxt)
          ST_ION_WAIT: state_nxt = ST_ION_DLY;
          ST_ION_DLY, ST_ON: begin
            if (any_req) begin
              take_nxt  = 1'b1;
              state_nxt = ST_OFF;
            end else begin
              state_nxt = ST_ON;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_OFF;
      irq_take  <= 1'b0;
      irq_src   <= '0;
      caf_clr   <= 1'b0;
      link_load <= 1'b0;
      link_val  <= 1'b0;
    end else begin
      state     <= state_nxt;
      irq_take  <= take_nxt & ~irq_take;
      if (take_nxt) irq_src <= grant_idx;
      caf_clr   <= op_caf & ~caf_clr;
      link_load <= op_rtf & ~link_load;
      link_val  <= op_rtf & ~link_load & DATA_IN[11];
    end
  end

  assign SKIP      = (op_skon & (state != ST_OFF)) | (op_srq & any_req);
  assign IE        = (state == ST_ION_DLY) || (state == ST_ON);
  assign IRQ_TAKE  = irq_take;
  assign IRQ_SRC   = irq_src;
  assign CAF_CLR   = caf_clr;
  assign LINK_LOAD = link_load;
  assign LINK_VAL  = link_val;
  assign state_dbg = state;

endmodule

// File: tb/tb_iot_interrupt_ctrl.sv
// Bench for iot_interrupt_ctrl: directed vector table, hand sequences, and random stimulus
// checked against a countdown-based model of the interrupt-enable rules.
module tb_iot_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        iot600x;
  logic [2:0]  ir_lo;
  logic        exec_stb;
  logic        instr_done;
  logic [7:0]  dev_req;
  logic        link_in;
  logic [11:0] data_in;
  logic        skip, ie, irq_take, caf_clr, link_load, link_val;
  logic [2:0]  irq_src;
  logic [11:0] data_out;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  iot_interrupt_ctrl #(.NDEV(8), .SRCW(3)) dut (
    .CLK(clk), .RESET(reset), .IOT600X(iot600x), .IR_LO(ir_lo), .EXEC_STB(exec_stb),
    .INSTR_DONE(instr_done), .DEV_REQ(dev_req), .LINK_IN(link_in), .DATA_IN(data_in),
    .SKIP(skip), .IE(ie), .IRQ_TAKE(irq_take), .IRQ_SRC(irq_src), .CAF_CLR(caf_clr),
    .DATA_OUT(data_out), .LINK_LOAD(link_load), .LINK_VAL(link_val), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic iot, input logic [2:0] ir, input logic d,
                       input logic [7:0] r, input logic l, input logic [11:0] di);
    exec_stb = e; iot600x = iot; ir_lo = ir; instr_done = d; dev_req = r;
    link_in = l; data_in = di;
  endtask

  // directed vector table
  typedef struct {
    logic       e, iot;
    logic [2:0] ir;
    logic       d;
    logic [7:0] r;
    logic       x_skip, x_ie, x_take;
    logic [2:0] x_src;
    logic       x_caf;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic e, input logic iot, input logic [2:0] ir, input logic d,
                     input logic [7:0] r, input logic xs, input logic xi, input logic xt,
                     input logic [2:0] xsrc, input logic xc);
    vec_t v;
    v.e = e; v.iot = iot; v.ir = ir; v.d = d; v.r = r;
    v.x_skip = xs; v.x_ie = xi; v.x_take = xt; v.x_src = xsrc; v.x_caf = xc;
    vecs.push_back(v);
  endtask

  // reference model: cd = -1 disabled, 2 = ION seen in current instruction,
  // 1 = one more instruction to finish, 0 = enabled
  int         m_cd;
  logic [2:0] m_src;
  logic       m_prev_caf, m_prev_ll;
  logic       x_skip, x_take, x_caf, x_ll, x_lv;
  logic [11:0] x_dout;

  function automatic logic [2:0] lowest(input logic [7:0] r);
    for (int i = 0; i < 8; i++) if (r[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_cd = -1; m_src = 3'd0; m_prev_caf = 1'b0; m_prev_ll = 1'b0;
  endtask

  task automatic model_comb();
    logic ex;
    ex     = exec_stb && iot600x;
    x_skip = ex && ((ir_lo == 3'd0 && m_cd >= 0) || (ir_lo == 3'd3 && dev_req != 8'd0));
    x_dout = 12'd0;
`ifdef IOT_INT_GTF_RTF_EN
    if (ex && ir_lo == 3'd4)
      x_dout = 12'(int'(link_in) * 2048 + int'(dev_req != 0) * 512 + int'(m_cd >= 0) * 128);
`endif
  endtask

  task automatic model_edge();
    logic ex, stop, rtf;
    ex = exec_stb && iot600x; stop = 1'b0; rtf = 1'b0; x_take = 1'b0;
    if (ex) begin
      if (ir_lo == 3'd0 || ir_lo == 3'd2 || ir_lo == 3'd7) begin m_cd = -1; stop = 1'b1; end
      if (ir_lo == 3'd1 && m_cd < 0) m_cd = 2;
`ifdef IOT_INT_GTF_RTF_EN
      if (ir_lo == 3'd5) begin
        rtf = 1'b1;
        if (data_in[7]) begin if (m_cd < 0) m_cd = 2; end
        else begin m_cd = -1; stop = 1'b1; end
      end
`endif
    end
    if (instr_done && !stop) begin
      if (m_cd == 2) m_cd = 1;
      else if (m_cd >= 0) begin
        if (dev_req != 0) begin x_take = 1'b1; m_cd = -1; m_src = lowest(dev_req); end
        else m_cd = 0;
      end
    end
    x_caf = ex && ir_lo == 3'd7 && !m_prev_caf;
    x_ll  = rtf && !m_prev_ll;
    x_lv  = x_ll && data_in[11];
    m_prev_caf = x_caf;
    m_prev_ll  = x_ll;
  endtask

  task automatic rand_step();
    drive($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
          $urandom_range(0, 2) == 0,
          ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
          1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
    #1;
    model_comb();
    chk("rnd_skip", skip, x_skip);
    chk("rnd_data_out", data_out, x_dout);
    model_edge();
    @(posedge clk); #1;
    chk("rnd_ie", ie, (m_cd == 0 || m_cd == 1));
    chk("rnd_irq_take", irq_take, x_take);
    chk("rnd_irq_src", irq_src, m_src);
    chk("rnd_caf_clr", caf_clr, x_caf);
    chk("rnd_link_load", link_load, x_ll);
    chk("rnd_link_val", link_val, x_lv);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 3'd0, 0, 8'h00, 0, 12'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 3'd0, 0, 8'h00, 0, 12'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ie", ie, 1'b0);
    chk("reset_irq_take", irq_take, 1'b0);
    chk("reset_irq_src", irq_src, 3'd0);
    chk("reset_caf_clr", caf_clr, 1'b0);
    chk("reset_link_load", link_load, 1'b0);
    chk("reset_link_val", link_val, 1'b0);
    chk("reset_data_out", data_out, 12'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    //   e iot ir d  req    skip ie take src caf
    add(0, 0, 0, 0, 8'h04,  0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 8'h04,  0, 0, 0, 0, 0);  // ION
    add(0, 0, 0, 1, 8'h04,  0, 1, 0, 0, 0);  // ION's own boundary: no take
    add(0, 0, 0, 0, 8'h04,  0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 8'h04,  0, 0, 1, 2, 0);  // next boundary takes device 2
    add(0, 0, 0, 0, 8'h04,  0, 0, 0, 2, 0);
    add(1, 1, 1, 1, 8'hFF,  0, 1, 0, 2, 0);  // ION + done together
    add(1, 1, 2, 1, 8'hFF,  0, 0, 0, 2, 0);  // IOF beats INSTR_DONE
    add(0, 0, 0, 1, 8'hFF,  0, 0, 0, 2, 0);
    add(1, 1, 1, 1, 8'h00,  0, 1, 0, 2, 0);
    add(0, 0, 0, 1, 8'h00,  0, 1, 0, 2, 0);  // ON
    add(0, 0, 0, 1, 8'h90,  0, 0, 1, 4, 0);
    add(0, 0, 0, 1, 8'h90,  0, 0, 0, 4, 0);  // no second pulse
    add(1, 1, 1, 1, 8'h00,  0, 1, 0, 4, 0);
    add(0, 1, 0, 0, 8'h00,  0, 1, 0, 4, 0);  // SKON without strobe does nothing
    add(0, 0, 0, 1, 8'h00,  0, 1, 0, 4, 0);
    add(1, 1, 0, 0, 8'h00,  1, 0, 0, 4, 0);  // SKON in ON
    add(1, 1, 0, 0, 8'h00,  0, 0, 0, 4, 0);  // SKON in OFF
    add(1, 1, 3, 0, 8'h00,  0, 0, 0, 4, 0);  // SRQ, no request
    add(1, 1, 3, 0, 8'h01,  1, 0, 0, 4, 0);  // SRQ, request
    add(1, 0, 1, 1, 8'h00,  0, 0, 0, 4, 0);  // not group 600x
    add(1, 1, 1, 1, 8'h00,  0, 1, 0, 4, 0);
    add(0, 0, 0, 1, 8'h00,  0, 1, 0, 4, 0);
    add(1, 1, 7, 0, 8'h00,  0, 0, 0, 4, 1);  // CAF in ON
    add(0, 0, 0, 0, 8'h00,  0, 0, 0, 4, 0);
    add(1, 1, 7, 0, 8'h00,  0, 0, 0, 4, 1);
    add(1, 1, 7, 0, 8'h00,  0, 0, 0, 4, 0);  // back-to-back CAF not extended
    add(1, 1, 6, 1, 8'h05,  0, 0, 0, 4, 0);  // 6006 no-op
    add(1, 1, 1, 1, 8'h00,  0, 1, 0, 4, 0);
    add(0, 0, 0, 1, 8'h81,  0, 0, 1, 0, 0);  // bit 0 beats bit 7
    add(0, 0, 0, 0, 8'h81,  0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].e, vecs[i].iot, vecs[i].ir, vecs[i].d, vecs[i].r, 1'b0, 12'd0);
      #1;
      chk($sformatf("vec%0d_skip", i), skip, vecs[i].x_skip);
      chk($sformatf("vec%0d_data_out", i), data_out, 12'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ie", i), ie, vecs[i].x_ie);
      chk($sformatf("vec%0d_irq_take", i), irq_take, vecs[i].x_take);
      chk($sformatf("vec%0d_irq_src", i), irq_src, vecs[i].x_src);
      chk($sformatf("vec%0d_caf_clr", i), caf_clr, vecs[i].x_caf);
      chk($sformatf("vec%0d_link_load", i), link_load, 1'b0);
    end

    // reset asserted while IRQ_TAKE is high drops it without a clock edge
    drive(1, 1, 3'd1, 1, 8'h00, 0, 12'd0);
    @(posedge clk); #1;
    drive(0, 0, 3'd0, 1, 8'h08, 0, 12'd0);
    @(posedge clk); #1;
    chk("rst_mid_take_before", irq_take, 1'b1);
    chk("rst_mid_src_before", irq_src, 3'd3);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_take_after", irq_take, 1'b0);
    chk("rst_mid_src_after", irq_src, 3'd0);
    #1 reset = 1'b0;
    drive(0, 0, 3'd0, 0, 8'h00, 0, 12'd0);
    @(posedge clk); #1;

`ifdef IOT_INT_GTF_RTF_EN
    drive(1, 1, 3'd1, 1, 8'h00, 1, 12'd0);
    @(posedge clk); #1;
    drive(0, 0, 3'd0, 1, 8'h00, 1, 12'd0);
    @(posedge clk); #1;
    drive(1, 1, 3'd4, 0, 8'h20, 1, 12'd0);  // GTF in ON
    #1;
    chk("gtf_data_out", data_out, 12'o5200);
    @(posedge clk); #1;
    drive(1, 1, 3'd2, 0, 8'h00, 0, 12'd0);  // IOF
    @(posedge clk); #1;
    drive(1, 1, 3'd5, 0, 8'h00, 0, 12'o4200);  // RTF enabling
    @(posedge clk); #1;
    chk("rtf_link_load", link_load, 1'b1);
    chk("rtf_link_val", link_val, 1'b1);
    chk("rtf_ie_wait", ie, 1'b0);
    drive(0, 0, 3'd0, 1, 8'h00, 0, 12'd0);
    @(posedge clk); #1;
    chk("rtf_link_load_drop", link_load, 1'b0);
    chk("rtf_ie_delay", ie, 1'b1);
    drive(0, 0, 3'd0, 0, 8'h00, 0, 12'd0);
    @(posedge clk); #1;
`endif

    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) rand_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
